fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the 4K×10 instruction ROM for the CSE141L core. It owns the program counter, drives the ROM address and registers the returned word into an instruction register for decode. It also applies stalls, absolute and relative branch redirects and halt, and reports start/done status and a retired-instruction count to the top level.

---
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the ROM address and registers
// the returned word for decode, with stall, branch redirect, halt and retire count.
module fetch_sequencer #(
  parameter int A  = 12,
  parameter int W  = 10,
  parameter int OW = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic [W-1:0]  InstIn,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [A-1:0]  Target,
  input  logic [OW-1:0] Offset,
  input  logic          Halt,
  output logic [A-1:0]  InstAddress,
  output logic [W-1:0]  Inst,
  output logic [A-1:0]  InstPc,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
  output logic [15:0]   InstCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [W-1:0]   inst_q, inst_d;
  logic [A-1:0]   ipc_q, ipc_d;
  logic           vld_q, vld_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [A-1:0]   br_tgt;

  // Relative target is taken from the IR's own address, not the fetch PC.
  assign br_tgt = BranchRel ? ipc_q + {{(A-OW){Offset[OW-1]}}, Offset} : Target;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = StartAddr;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (Stall) begin
          // hold everything
        end else if (Halt && vld_q) begin
          state_d = S_DONE;
          vld_d   = 1'b0;
          pc_d    = ipc_q;
          cnt_d   = cnt_q + 16'd1;
        end else if (BranchEn && vld_q) begin
          // squash the sequential word already on the ROM bus
          pc_d    = br_tgt;
          vld_d   = 1'b0;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          inst_d  = InstIn;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_q + 1'b1;
          if (vld_q) cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign InstAddress = pc_q;
  assign Inst        = inst_q;
  assign InstPc      = ipc_q;
  assign InstValid   = vld_q;
  assign Busy        = (state_q == S_RUN);
  assign Done        = (state_q == S_DONE);
  assign InstCount   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: combinational ROM model, hand-computed
// expected PC / IR / count values at each step.
module tb_fetch_sequencer;
  localparam int A = 12, W = 10, OW = 8;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Start, Stall, BranchEn, BranchRel, Halt;
  logic [A-1:0]  StartAddr, Target;
  logic [OW-1:0] Offset;
  logic [W-1:0]  InstIn;
  logic [A-1:0]  InstAddress, InstPc;
  logic [W-1:0]  Inst;
  logic          InstValid, Busy, Done;
  logic [15:0]   InstCount;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer #(.A(A), .W(W), .OW(OW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .InstIn(InstIn), .Stall(Stall), .BranchEn(BranchEn), .BranchRel(BranchRel),
    .Target(Target), .Offset(Offset), .Halt(Halt), .InstAddress(InstAddress),
    .Inst(Inst), .InstPc(InstPc), .InstValid(InstValid), .Busy(Busy),
    .Done(Done), .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  // ROM contents scrambled so an address/data mixup shows up
  function automatic logic [W-1:0] rom(input logic [A-1:0] a);
    return a[W-1:0] ^ 10'h2A5;
  endfunction

  assign InstIn = rom(InstAddress);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // check the fetch-visible state after an edge
  task automatic st(input string tag, input logic [A-1:0] pc, input logic v,
                    input logic [A-1:0] ipc, input logic [15:0] cnt);
    chk({tag, ".pc"},    InstAddress, pc);
    chk({tag, ".vld"},   InstValid,   v);
    if (v) begin
      chk({tag, ".ipc"},  InstPc, ipc);
      chk({tag, ".inst"}, Inst,   rom(ipc));
    end
    chk({tag, ".cnt"},   InstCount,   cnt);
  endtask

  initial begin
    Reset_n = 1'b0; Start = 0; Stall = 0; BranchEn = 0; BranchRel = 0; Halt = 0;
    StartAddr = '0; Target = '0; Offset = '0;
    #23 Reset_n = 1'b1;
    repeat (10) begin
      step();
      chk("idle.pc", InstAddress, 0);
    end
    chk("idle.inst", Inst, 0);
    chk("idle.ipc",  InstPc, 0);
    chk("idle.vld",  InstValid, 0);
    chk("idle.busy", Busy, 0);
    chk("idle.done", Done, 0);
    chk("idle.cnt",  InstCount, 0);

    // straight-line fetch from 0x010
    StartAddr = 12'h010; Start = 1;
    step(); Start = 0;
    chk("start.busy", Busy, 1);
    st("start", 12'h010, 0, 0, 0);
    step(); st("f0", 12'h011, 1, 12'h010, 0);
    step(); st("f1", 12'h012, 1, 12'h011, 1);
    step(); st("f2", 12'h013, 1, 12'h012, 2);

    // absolute branch to 0x200
    BranchEn = 1; Target = 12'h200;
    step(); BranchEn = 0;
    st("babs", 12'h200, 0, 0, 3);
    step(); st("babs1", 12'h201, 1, 12'h200, 3);
    step(); st("babs2", 12'h202, 1, 12'h201, 4);

    // relative branch -2 from 0x201
    BranchEn = 1; BranchRel = 1; Offset = 8'hFE;
    step(); BranchEn = 0; BranchRel = 0;
    st("brel", 12'h1FF, 0, 0, 5);
    step(); st("brel1", 12'h200, 1, 12'h1FF, 5);

    // stall beats halt and branch
    Stall = 1; BranchEn = 1; Halt = 1; Target = 12'h300;
    repeat (3) begin
      step();
      st("stall", 12'h200, 1, 12'h1FF, 5);
      chk("stall.busy", Busy, 1);
    end
    Stall = 0;
    step(); BranchEn = 0; Halt = 0;
    chk("halt.done", Done, 1);
    chk("halt.busy", Busy, 0);
    st("halt", 12'h1FF, 0, 0, 6);
    step(); st("doneidle", 12'h1FF, 0, 0, 6);
    chk("doneidle.done", Done, 1);

    // restart from DONE at 0xFFE, wrap
    StartAddr = 12'hFFE; Start = 1;
    step(); Start = 0;
    chk("rs.busy", Busy, 1);
    st("rs", 12'hFFE, 0, 0, 0);
    step(); st("w0", 12'hFFF, 1, 12'hFFE, 0);
    step(); st("w1", 12'h000, 1, 12'hFFF, 1);
    BranchEn = 1; BranchRel = 1; Offset = 8'h03;
    step(); BranchEn = 0; BranchRel = 0;
    st("wrel", 12'h002, 0, 0, 2);
    step(); st("wrel1", 12'h003, 1, 12'h002, 2);

    // Start in RUN is ignored
    Start = 1; StartAddr = 12'h100;
    step(); Start = 0;
    st("runstart", 12'h004, 1, 12'h003, 3);
    chk("runstart.busy", Busy, 1);

    // asynchronous reset mid-run
    #3 Reset_n = 1'b0;
    #1;
    chk("arst.pc",   InstAddress, 0);
    chk("arst.inst", Inst, 0);
    chk("arst.ipc",  InstPc, 0);
    chk("arst.vld",  InstValid, 0);
    chk("arst.busy", Busy, 0);
    chk("arst.done", Done, 0);
    chk("arst.cnt",  InstCount, 0);
    #8 Reset_n = 1'b1;
    step(); step();
    chk("post.busy", Busy, 0);
    chk("post.pc",   InstAddress, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
